// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte requesters.
// Optional WAIT abort timeout is enabled with `define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [2:0]             baud_cfg,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   send_en,
    output logic [7:0]             data_byte,
    output logic [2:0]             baud_set,
    input  logic                   tx_done,
    output logic                   tx_timeout
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Unsupported configurations elaborate this marker block.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_unsupported_cfg
    end

    state_t               r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_gnt;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_busy;
    logic                 r_send_en;
    logic [7:0]           r_data;
    logic [2:0]           r_baud;

    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [IDX_W-1:0]     w_cand;
    logic                 w_to_hit;

    // Round-robin search starting one past the last grant.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % int'(NUM_REQ));
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_to_hit   = (r_state == S_WAIT) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign tx_timeout = r_timeout;

    // Cycles spent in WAIT since send_en; cleared at every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT && !tx_done) begin
                if (w_to_hit) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign w_to_hit   = 1'b0;
    assign tx_timeout = 1'b0;
`endif

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= IDX_W'(NUM_REQ - 1);
            r_gnt     <= '0;
            r_gap_cnt <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_send_en <= 1'b0;
            r_data    <= 8'h00;
            r_baud    <= 3'd0;
        end else begin
            r_ack     <= '0;
            r_done    <= '0;
            r_send_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt     <= w_win;
                        r_ptr     <= w_win;
                        r_data    <= req_data[{w_win, 3'b000} +: 8];
                        r_baud    <= baud_cfg;
                        r_ack     <= NUM_REQ'(1) << w_win;
                        r_send_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_done) begin
                        r_done <= NUM_REQ'(1) << r_gnt;
                    end
                    if (tx_done || w_to_hit) begin
                        r_gap_cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign done      = r_done;
    assign busy      = r_busy;
    assign send_en   = r_send_en;
    assign data_byte = r_data;
    assign baud_set  = r_baud;

endmodule
